// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state type, byte-enable patterns and access-decoding helpers.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } mau_state_e;

    // True when funct3 is not legal for the access kind or the address
    // is not naturally aligned for the access size.
    function automatic logic access_fault(input logic is_write,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic bad_f3;
        logic bad_align;
        bad_f3    = 1'b0;
        bad_align = 1'b0;
        case (f3)
            3'b000:  bad_f3 = 1'b0;
            3'b001:  bad_f3 = 1'b0;
            3'b010:  bad_f3 = 1'b0;
            3'b100:  bad_f3 = is_write;
            3'b101:  bad_f3 = is_write;
            default: bad_f3 = 1'b1;
        endcase
        case (f3[1:0])
            2'b01:   bad_align = addr_lo[0];
            2'b10:   bad_align = (addr_lo != 2'b00);
            default: bad_align = 1'b0;
        endcase
        return bad_f3 | bad_align;
    endfunction

    // Byte enables for the lanes touched by an access of this size.
    function automatic logic [3:0] lane_be(input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = BE_BYTE0 << addr_lo;
            2'b01:   be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            2'b10:   be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the enabled lane is correct.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3,
                                                input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            2'b10:   d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/ready data-bus bundle between the load/store unit and memory.
interface mem_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and
// sign- or zero-extends it according to the load funct3.
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by size/sign extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = 32'h0000_0000;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  data = {24'h00_0000, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LHU:  data = {16'h0000, half_s};
            F3_LW:   data = rdata;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus transaction per EX/MEM instruction,
// stalling the pipeline until the bus answers or the wait budget expires.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic [31:0] readdata,
    output logic        misaligned,
    output logic        bus_error,
    mem_bus_if.master   bus
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    mau_state_e        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              err_q, err_d;

    logic              access_s;
    logic              fault_s;
    logic [31:0]       align_data_s;

    assign access_s = mem_read | mem_write;
    assign fault_s  = access_fault(mem_write, funct3, address[1:0]);

    load_align u_load_align (
        .rdata   (bus.bus_rdata),
        .addr_lo (off_q),
        .funct3  (funct3_q),
        .data    (align_data_s)
    );

    // Next-state, stall/fault decode and transaction bookkeeping.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        wait_d      = wait_q;
        readdata_d  = readdata_q;
        err_d       = err_q;
        stall       = 1'b0;
        misaligned  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_s && fault_s) begin
                    misaligned = 1'b1;
                end else if (access_s) begin
                    stall       = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {address[31:2], 2'b00};
                    bus_wdata_d = mem_write ? store_wdata(funct3, writedata) : 32'h0000_0000;
                    bus_be_d    = lane_be(funct3, address[1:0]);
                    funct3_d    = funct3;
                    off_d       = address[1:0];
                    wait_d      = '0;
                    state_d     = ST_ACCESS;
                end else begin
                    stall = 1'b0;
                end
            end
            ST_ACCESS: begin
                stall = 1'b1;
                if (bus.bus_ready) begin
                    readdata_d = bus_we_q ? 32'h0000_0000 : align_data_s;
                    bus_req_d  = 1'b0;
                    err_d      = 1'b0;
                    state_d    = ST_DONE;
                end else if (wait_q == WAIT_LAST) begin
                    readdata_d = 32'h0000_0000;
                    bus_req_d  = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DONE: begin
                // EX/MEM advances on this edge; readdata only lives in DONE.
                readdata_d = 32'h0000_0000;
                err_d      = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and bus-field registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            wait_q      <= '0;
            readdata_q  <= 32'h0000_0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            wait_q      <= wait_d;
            readdata_q  <= readdata_d;
            err_q       <= err_d;
        end
    end

    assign readdata      = readdata_q;
    assign bus_error     = err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_be    = bus_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (MAX_WAIT = 4).
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [2:0]  funct3;
    logic        stall;
    logic [31:0] readdata;
    logic        misaligned;
    logic        bus_error;

    int total;
    int bad;

    mem_bus_if bus_if ();

    mem_access_unit #(.MAX_WAIT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .writedata  (writedata),
        .funct3     (funct3),
        .stall      (stall),
        .readdata   (readdata),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .bus        (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // One legal access; waits = ACCESS cycles without ready before ready.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input int waits, input logic [31:0] exp_rd,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        address   = addr;
        writedata = wd;
        #3;
        chk({tag, ".stall_T"}, 32'(stall), 32'd1);
        chk({tag, ".mis_T"}, 32'(misaligned), 32'd0);
        chk({tag, ".req_T"}, 32'(bus_if.bus_req), 32'd0);
        next_cycle();
        for (int i = 0; i < waits; i++) begin
            chk({tag, ".req_wait"}, 32'(bus_if.bus_req), 32'd1);
            chk({tag, ".stall_wait"}, 32'(stall), 32'd1);
            next_cycle();
        end
        chk({tag, ".req"}, 32'(bus_if.bus_req), 32'd1);
        chk({tag, ".stall_acc"}, 32'(stall), 32'd1);
        chk({tag, ".addr"}, bus_if.bus_addr, exp_addr);
        chk({tag, ".be"}, 32'(bus_if.bus_be), 32'(exp_be));
        chk({tag, ".we"}, 32'(bus_if.bus_we), 32'(wr));
        if (wr) begin
            chk({tag, ".wdata"}, bus_if.bus_wdata, exp_wd);
        end
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = rdata;
        next_cycle();
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 32'h5A5A_5A5A;
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        chk({tag, ".readdata"}, readdata, exp_rd);
        chk({tag, ".req_done"}, 32'(bus_if.bus_req), 32'd0);
        chk({tag, ".berr_done"}, 32'(bus_error), 32'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        next_cycle();
        chk({tag, ".rd_idle"}, readdata, 32'h0000_0000);
        chk({tag, ".stall_idle"}, 32'(stall), 32'd0);
    endtask

    // Faulting access: flagged combinationally, never reaches the bus.
    task automatic bad_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        address   = addr;
        writedata = 32'hFFFF_FFFF;
        #3;
        chk({tag, ".mis"}, 32'(misaligned), 32'd1);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".req"}, 32'(bus_if.bus_req), 32'd0);
        chk({tag, ".rd"}, readdata, 32'h0000_0000);
        next_cycle();
        chk({tag, ".req_next"}, 32'(bus_if.bus_req), 32'd0);
        chk({tag, ".mis_hold"}, 32'(misaligned), 32'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #3;
        chk({tag, ".mis_clear"}, 32'(misaligned), 32'd0);
        next_cycle();
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        address          = 32'h0000_0000;
        writedata        = 32'h0000_0000;
        funct3           = 3'b000;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 32'h0000_0000;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.mis", 32'(misaligned), 32'd0);
        chk("rst.berr", 32'(bus_error), 32'd0);
        chk("rst.req", 32'(bus_if.bus_req), 32'd0);
        chk("rst.we", 32'(bus_if.bus_we), 32'd0);
        chk("rst.addr", bus_if.bus_addr, 32'h0000_0000);
        chk("rst.be", 32'(bus_if.bus_be), 32'd0);
        chk("rst.wdata", bus_if.bus_wdata, 32'h0000_0000);
        chk("rst.rd", readdata, 32'h0000_0000);

        // bus_ready in IDLE with no access must not start anything
        bus_if.bus_ready = 1'b1;
        next_cycle();
        chk("idle_rdy.req", 32'(bus_if.bus_req), 32'd0);
        chk("idle_rdy.stall", 32'(stall), 32'd0);
        bus_if.bus_ready = 1'b0;
        next_cycle();

        run_txn("lw",   1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0,
                32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0);
        run_txn("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0,
                32'hFFFF_FF80, 32'h0000_0100, 4'b1000, 32'h0);
        run_txn("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 0,
                32'h0000_0080, 32'h0000_0100, 4'b1000, 32'h0);
        run_txn("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8011_2233, 0,
                32'h0000_8011, 32'h0000_0100, 4'b1100, 32'h0);
        run_txn("lh_hi", 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8011_2233, 2,
                32'hFFFF_8011, 32'h0000_0100, 4'b1100, 32'h0);
        run_txn("lh_lo", 1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h8011_2233, 1,
                32'h0000_2233, 32'h0000_0100, 4'b0011, 32'h0);
        run_txn("lb1",  1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h8011_7F33, 0,
                32'h0000_007F, 32'h0000_0100, 4'b0010, 32'h0);
        run_txn("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'hFFFF_FFFF, 0,
                32'h0000_0000, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB);
        run_txn("sh",   1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_CDEF, 32'hFFFF_FFFF, 0,
                32'h0000_0000, 32'h0000_0200, 4'b1100, 32'hCDEF_CDEF);
        run_txn("sw",   1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h1234_5678, 32'hFFFF_FFFF, 1,
                32'h0000_0000, 32'h0000_0204, 4'b1111, 32'h1234_5678);
        run_txn("rw_both", 1'b1, 1'b1, 3'b010, 32'h0000_0208, 32'hCAFE_F00D, 32'h1111_1111, 0,
                32'h0000_0000, 32'h0000_0208, 4'b1111, 32'hCAFE_F00D);

        bad_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0102);
        bad_access("f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100);
        bad_access("lh_odd", 1'b1, 1'b0, 3'b001, 32'h0000_0101);
        bad_access("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_0100);

        // Timeout: bus never ready, request held for exactly MAX_WAIT cycles
        mem_read = 1'b1;
        funct3   = 3'b010;
        address  = 32'h0000_0400;
        bus_if.bus_rdata = 32'h7777_7777;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            chk("to.req", 32'(bus_if.bus_req), 32'd1);
            chk("to.stall", 32'(stall), 32'd1);
            next_cycle();
        end
        chk("to.req_done", 32'(bus_if.bus_req), 32'd0);
        chk("to.berr", 32'(bus_error), 32'd1);
        chk("to.rd", readdata, 32'h0000_0000);
        chk("to.stall_done", 32'(stall), 32'd0);
        mem_read = 1'b0;
        next_cycle();
        chk("to.berr_clear", 32'(bus_error), 32'd0);
        chk("to.req_idle", 32'(bus_if.bus_req), 32'd0);

        // Reset in the middle of ACCESS abandons the request
        mem_read = 1'b1;
        funct3   = 3'b010;
        address  = 32'h0000_0500;
        next_cycle();
        chk("rstacc.req", 32'(bus_if.bus_req), 32'd1);
        reset    = 1'b1;
        mem_read = 1'b0;
        next_cycle();
        chk("rstacc.req_drop", 32'(bus_if.bus_req), 32'd0);
        chk("rstacc.stall", 32'(stall), 32'd0);
        reset = 1'b0;
        run_txn("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 0,
                32'h0BAD_F00D, 32'h0000_0300, 4'b1111, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
